// File: rtl/calc_pkg.sv
// Shared calculator definitions: command codes, keypad FSM states and key-to-command mapping.
package calc_pkg;

    localparam int unsigned CMD_W    = 4;
    localparam int unsigned KEY_IDX_W = 2;

    localparam logic [CMD_W-1:0] CMD_DIGIT0 = 4'd0;
    localparam logic [CMD_W-1:0] CMD_DIGIT1 = 4'd1;
    localparam logic [CMD_W-1:0] CMD_DIGIT2 = 4'd2;
    localparam logic [CMD_W-1:0] CMD_DIGIT3 = 4'd3;
    localparam logic [CMD_W-1:0] CMD_DIGIT4 = 4'd4;
    localparam logic [CMD_W-1:0] CMD_DIGIT5 = 4'd5;
    localparam logic [CMD_W-1:0] CMD_DIGIT6 = 4'd6;
    localparam logic [CMD_W-1:0] CMD_DIGIT7 = 4'd7;
    localparam logic [CMD_W-1:0] CMD_DIGIT8 = 4'd8;
    localparam logic [CMD_W-1:0] CMD_DIGIT9 = 4'd9;
    localparam logic [CMD_W-1:0] CMD_ADD    = 4'b1010;
    localparam logic [CMD_W-1:0] CMD_SUB    = 4'b1011;
    localparam logic [CMD_W-1:0] CMD_MUL    = 4'b1100;
    localparam logic [CMD_W-1:0] CMD_SPARE  = 4'b1101;
    localparam logic [CMD_W-1:0] CMD_EQ     = 4'b1110;
    localparam logic [CMD_W-1:0] CMD_BKSP   = 4'b1111;

    typedef enum logic [1:0] {
        KP_SCAN         = 2'd0,
        KP_DEBOUNCE     = 2'd1,
        KP_EMIT         = 2'd2,
        KP_WAIT_RELEASE = 2'd3
    } kp_state_t;

    // One command beat as seen by the calculator core.
    typedef struct packed {
        logic             valid;
        logic [CMD_W-1:0] code;
    } cmd_beat_t;

    function automatic logic [CMD_W-1:0] key_to_cmd(input logic [KEY_IDX_W-1:0] row,
                                                    input logic [KEY_IDX_W-1:0] col);
        logic [CMD_W-1:0] code;
        code = CMD_DIGIT0;
        case ({row, col})
            4'b00_00: code = CMD_DIGIT1;
            4'b00_01: code = CMD_DIGIT2;
            4'b00_10: code = CMD_DIGIT3;
            4'b00_11: code = CMD_ADD;
            4'b01_00: code = CMD_DIGIT4;
            4'b01_01: code = CMD_DIGIT5;
            4'b01_10: code = CMD_DIGIT6;
            4'b01_11: code = CMD_SUB;
            4'b10_00: code = CMD_DIGIT7;
            4'b10_01: code = CMD_DIGIT8;
            4'b10_10: code = CMD_DIGIT9;
            4'b10_11: code = CMD_MUL;
            4'b11_00: code = CMD_BKSP;
            4'b11_01: code = CMD_DIGIT0;
            4'b11_10: code = CMD_EQ;
            4'b11_11: code = CMD_SPARE;
            default:  code = CMD_DIGIT0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with a configurable width and reset value.
module sync_2ff #(
    parameter int unsigned     WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_cmd_gen.sv
// 4x4 keypad scanner with press/release debounce; emits one command pulse per accepted key.
module keypad_cmd_gen
    import calc_pkg::*;
#(
    parameter int unsigned SCAN_CYCLES     = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       row_in,
    output logic [3:0]       col_out,
    output logic [CMD_W-1:0] cmd,
    output logic             cmd_valid,
    output logic             key_held
);

    localparam int unsigned SCAN_W = $clog2(SCAN_CYCLES);
    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [SCAN_W-1:0] SCAN_LAST    = SCAN_W'(SCAN_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_MAX      = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0]  DEB_REL_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0] row_sync;

    kp_state_t            state_q,    state_d;
    logic [SCAN_W-1:0]    scan_cnt_q, scan_cnt_d;
    logic [DEB_W-1:0]     deb_cnt_q,  deb_cnt_d;
    logic [KEY_IDX_W-1:0] col_idx_q,  col_idx_d;
    logic [KEY_IDX_W-1:0] row_lat_q,  row_lat_d;
    logic [3:0]           col_out_q,  col_out_d;
    cmd_beat_t            beat_q,     beat_d;
    logic                 key_held_q, key_held_d;

    logic [KEY_IDX_W-1:0] low_row;
    logic                 lat_row_low;

    sync_2ff #(
        .WIDTH     (4),
        .RESET_VAL (4'hF)
    ) u_row_sync (
        .clk   (clock),
        .rst_n (reset),
        .d_i   (row_in),
        .q_o   (row_sync)
    );

    // Lowest-index active (low) row wins when several rows are pulled down.
    always_comb begin
        low_row = 2'd3;
        if (!row_sync[2]) low_row = 2'd2;
        if (!row_sync[1]) low_row = 2'd1;
        if (!row_sync[0]) low_row = 2'd0;
    end

    assign lat_row_low = ~row_sync[row_lat_q];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= KP_SCAN;
            scan_cnt_q <= '0;
            deb_cnt_q  <= '0;
            col_idx_q  <= '0;
            row_lat_q  <= '0;
            col_out_q  <= 4'b1110;
            beat_q     <= '0;
            key_held_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            scan_cnt_q <= scan_cnt_d;
            deb_cnt_q  <= deb_cnt_d;
            col_idx_q  <= col_idx_d;
            row_lat_q  <= row_lat_d;
            col_out_q  <= col_out_d;
            beat_q     <= beat_d;
            key_held_q <= key_held_d;
        end
    end

    // Next state; outputs are derived from the next state so the registered copies line up with it.
    always_comb begin
        state_d    = state_q;
        scan_cnt_d = scan_cnt_q;
        deb_cnt_d  = deb_cnt_q;
        col_idx_d  = col_idx_q;
        row_lat_d  = row_lat_q;

        case (state_q)
            KP_SCAN: begin
                if (scan_cnt_q == SCAN_LAST) begin
                    scan_cnt_d = '0;
                    if (row_sync != 4'hF) begin
                        row_lat_d = low_row;
                        deb_cnt_d = DEB_W'(1);
                        state_d   = KP_DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
                end
            end
            KP_DEBOUNCE: begin
                if (!lat_row_low) begin
                    deb_cnt_d  = '0;
                    scan_cnt_d = '0;
                    col_idx_d  = col_idx_q + 2'd1;
                    state_d    = KP_SCAN;
                end else if (deb_cnt_q == DEB_MAX) begin
                    state_d = KP_EMIT;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            KP_EMIT: begin
                deb_cnt_d = '0;
                state_d   = KP_WAIT_RELEASE;
            end
            KP_WAIT_RELEASE: begin
                if (lat_row_low) begin
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_REL_LAST) begin
                    deb_cnt_d  = '0;
                    scan_cnt_d = '0;
                    col_idx_d  = '0;
                    state_d    = KP_SCAN;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            default: begin
                state_d = KP_SCAN;
            end
        endcase

        col_out_d    = ~(4'b0001 << col_idx_d);
        beat_d.valid = (state_d == KP_EMIT);
        beat_d.code  = beat_d.valid ? key_to_cmd(row_lat_d, col_idx_d) : CMD_DIGIT0;
        key_held_d   = (state_d == KP_EMIT) || (state_d == KP_WAIT_RELEASE);
    end

    assign col_out   = col_out_q;
    assign cmd       = beat_q.code;
    assign cmd_valid = beat_q.valid;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_cmd_gen.sv
// Directed bench for keypad_cmd_gen using a column-to-row short keypad model.
module tb_keypad_cmd_gen;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       key_held;

    logic [15:0] key_dn;
    int          vectors;
    int          miscompares;
    logic [3:0]  pulse_cmd[$];
    int          pulse_at[$];
    int          idle_bad;
    int          coll_cyc;

    keypad_cmd_gen #(
        .SCAN_CYCLES     (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .row_in    (row_in),
        .col_out   (col_out),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .key_held  (key_held)
    );

    always #5 clock = ~clock;

    // Pressed key (r,c) shorts column c to row r while that column is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (key_dn[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    // Runs n cycles, logging pulses and counting protocol breaks (cmd nonzero while idle, pulse without key_held).
    task automatic collect(input int n, input bit fresh);
        if (fresh) begin
            pulse_cmd.delete();
            pulse_at.delete();
            idle_bad = 0;
            coll_cyc = 0;
        end
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            if (cmd_valid === 1'b1) begin
                pulse_cmd.push_back(cmd);
                pulse_at.push_back(coll_cyc);
                if (key_held !== 1'b1) idle_bad++;
            end else if (cmd !== 4'd0 || cmd_valid !== 1'b0) begin
                idle_bad++;
            end
            coll_cyc++;
        end
    endtask

    task automatic test_reset;
        reset  = 1'b0;
        key_dn = 16'h0;
        repeat (3) @(posedge clock);
        #1;
        vectors++;
        if (col_out !== 4'b1110) begin
            miscompares++;
            $display("FAIL reset_col_out: got %b expected %b", col_out, 4'b1110);
        end
        vectors++;
        if (cmd !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_cmd: got %h expected %h", cmd, 4'd0);
        end
        vectors++;
        if (cmd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_cmd_valid: got %b expected 0", cmd_valid);
        end
        vectors++;
        if (key_held !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_key_held: got %b expected 0", key_held);
        end
        reset = 1'b1;
    endtask

    task automatic test_single_key;
        int lat;
        int n;
        logic [3:0] got;
        key_dn[0] = 1'b1;
        collect(40, 1'b1);
        vectors++;
        if (pulse_cmd.size() != 1) begin
            miscompares++;
            $display("FAIL single_count: got %0d pulses expected 1", pulse_cmd.size());
        end
        got = (pulse_cmd.size() > 0) ? pulse_cmd[0] : 4'hx;
        vectors++;
        if (got !== 4'd1) begin
            miscompares++;
            $display("FAIL single_cmd: got %h expected 1", got);
        end
        lat = (pulse_at.size() > 0) ? pulse_at[0] + 1 : -1;
        vectors++;
        if (lat < 7 || lat > 23) begin
            miscompares++;
            $display("FAIL single_latency: got %0d cycles expected 7..23", lat);
        end
        vectors++;
        if (key_held !== 1'b1) begin
            miscompares++;
            $display("FAIL single_held: got %b expected 1", key_held);
        end
        key_dn[0] = 1'b0;
        n = 0;
        do begin
            @(posedge clock); #1;
            n++;
        end while (key_held === 1'b1 && n < 30);
        vectors++;
        if (n != 6) begin
            miscompares++;
            $display("FAIL single_release: key_held fell after %0d cycles expected 6", n);
        end
        collect(20, 1'b1);
        vectors++;
        if (pulse_cmd.size() != 0 || idle_bad != 0) begin
            miscompares++;
            $display("FAIL single_after: got %0d pulses %0d idle errors expected 0 0", pulse_cmd.size(), idle_bad);
        end
    endtask

    task automatic test_sequence;
        int         keys[5];
        logic [3:0] exp_cmd[5];
        logic [3:0] got;
        keys    = '{0, 1, 3, 2, 14};
        exp_cmd = '{4'd1, 4'd2, 4'b1010, 4'd3, 4'b1110};
        for (int k = 0; k < 5; k++) begin
            key_dn        = 16'h0;
            key_dn[keys[k]] = 1'b1;
            collect(40, k == 0);
            key_dn = 16'h0;
            collect(20, 1'b0);
        end
        vectors++;
        if (pulse_cmd.size() != 5) begin
            miscompares++;
            $display("FAIL seq_count: got %0d pulses expected 5", pulse_cmd.size());
        end
        for (int k = 0; k < 5; k++) begin
            got = (pulse_cmd.size() > k) ? pulse_cmd[k] : 4'hx;
            vectors++;
            if (got !== exp_cmd[k]) begin
                miscompares++;
                $display("FAIL seq_cmd%0d: got %h expected %h", k, got, exp_cmd[k]);
            end
        end
        vectors++;
        if (idle_bad != 0) begin
            miscompares++;
            $display("FAIL seq_idle: got %0d idle errors expected 0", idle_bad);
        end
    endtask

    task automatic test_zero_key;
        logic [3:0] got;
        key_dn[13] = 1'b1;
        collect(40, 1'b1);
        key_dn[13] = 1'b0;
        collect(20, 1'b0);
        vectors++;
        if (pulse_cmd.size() != 1) begin
            miscompares++;
            $display("FAIL zero_count: got %0d pulses expected 1", pulse_cmd.size());
        end
        got = (pulse_cmd.size() > 0) ? pulse_cmd[0] : 4'hx;
        vectors++;
        if (got !== 4'd0) begin
            miscompares++;
            $display("FAIL zero_cmd: got %h expected 0", got);
        end
        vectors++;
        if (idle_bad != 0) begin
            miscompares++;
            $display("FAIL zero_idle: got %0d idle errors expected 0", idle_bad);
        end
    endtask

    task automatic test_bounce;
        logic [3:0] got;
        pulse_cmd.delete();
        for (int i = 0; i < 5; i++) begin
            key_dn[5] = 1'b1;
            collect(2, i == 0);
            key_dn[5] = 1'b0;
            collect(2, 1'b0);
        end
        key_dn[5] = 1'b1;
        collect(40, 1'b0);
        key_dn[5] = 1'b0;
        collect(20, 1'b0);
        vectors++;
        if (pulse_cmd.size() != 1) begin
            miscompares++;
            $display("FAIL bounce_count: got %0d pulses expected 1", pulse_cmd.size());
        end
        got = (pulse_cmd.size() > 0) ? pulse_cmd[0] : 4'hx;
        vectors++;
        if (got !== 4'd5) begin
            miscompares++;
            $display("FAIL bounce_cmd: got %h expected 5", got);
        end
        vectors++;
        if (idle_bad != 0) begin
            miscompares++;
            $display("FAIL bounce_idle: got %0d idle errors expected 0", idle_bad);
        end
    endtask

    task automatic test_glitch;
        key_dn[8] = 1'b1;
        collect(3, 1'b1);
        key_dn[8] = 1'b0;
        collect(40, 1'b0);
        vectors++;
        if (pulse_cmd.size() != 0) begin
            miscompares++;
            $display("FAIL glitch_count: got %0d pulses expected 0", pulse_cmd.size());
        end
        vectors++;
        if (key_held !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_held: got %b expected 0", key_held);
        end
    endtask

    task automatic test_two_keys;
        logic [3:0] got;
        key_dn[6]  = 1'b1;
        key_dn[10] = 1'b1;
        collect(40, 1'b1);
        vectors++;
        got = (pulse_cmd.size() > 0) ? pulse_cmd[0] : 4'hx;
        if (pulse_cmd.size() != 1 || got !== 4'd6) begin
            miscompares++;
            $display("FAIL two_first: got %0d pulses first %h expected 1 pulse of 6", pulse_cmd.size(), got);
        end
        key_dn[6] = 1'b0;
        collect(40, 1'b0);
        vectors++;
        if (pulse_cmd.size() != 2) begin
            miscompares++;
            $display("FAIL two_count: got %0d pulses expected 2", pulse_cmd.size());
        end
        got = (pulse_cmd.size() > 1) ? pulse_cmd[1] : 4'hx;
        vectors++;
        if (got !== 4'd9) begin
            miscompares++;
            $display("FAIL two_second: got %h expected 9", got);
        end
        key_dn[10] = 1'b0;
        collect(20, 1'b0);
        vectors++;
        if (pulse_cmd.size() != 2 || idle_bad != 0) begin
            miscompares++;
            $display("FAIL two_after: got %0d pulses %0d idle errors expected 2 0", pulse_cmd.size(), idle_bad);
        end
    endtask

    task automatic test_reset_mid;
        int         at;
        logic [3:0] got;
        reset  = 1'b0;
        key_dn = 16'h0;
        repeat (2) @(posedge clock);
        #1;
        reset     = 1'b1;
        key_dn[1] = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        vectors++;
        if (col_out !== 4'b1101) begin
            miscompares++;
            $display("FAIL mid_pre_col: got %b expected %b", col_out, 4'b1101);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (col_out !== 4'b1110) begin
            miscompares++;
            $display("FAIL mid_col_out: got %b expected %b", col_out, 4'b1110);
        end
        vectors++;
        if (cmd !== 4'd0 || cmd_valid !== 1'b0 || key_held !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_outputs: got cmd %h valid %b held %b expected 0 0 0", cmd, cmd_valid, key_held);
        end
        collect(3, 1'b1);
        vectors++;
        if (pulse_cmd.size() != 0) begin
            miscompares++;
            $display("FAIL mid_in_reset: got %0d pulses expected 0", pulse_cmd.size());
        end
        reset = 1'b1;
        collect(30, 1'b1);
        vectors++;
        if (pulse_cmd.size() != 1) begin
            miscompares++;
            $display("FAIL mid_count: got %0d pulses expected 1", pulse_cmd.size());
        end
        at = (pulse_at.size() > 0) ? pulse_at[0] + 1 : -1;
        vectors++;
        if (at != 12) begin
            miscompares++;
            $display("FAIL mid_latency: got %0d cycles expected 12", at);
        end
        got = (pulse_cmd.size() > 0) ? pulse_cmd[0] : 4'hx;
        vectors++;
        if (got !== 4'd2) begin
            miscompares++;
            $display("FAIL mid_cmd: got %h expected 2", got);
        end
        key_dn[1] = 1'b0;
        collect(20, 1'b0);
        vectors++;
        if (idle_bad != 0) begin
            miscompares++;
            $display("FAIL mid_idle: got %0d idle errors expected 0", idle_bad);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        idle_bad    = 0;
        coll_cyc    = 0;
        key_dn      = 16'h0;
        reset       = 1'b0;
        test_reset();
        test_single_key();
        test_sequence();
        test_zero_key();
        test_bounce();
        test_glitch();
        test_two_keys();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
